// File: rtl/config_axil_read_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : config_axil_read_bridge_if
// Purpose  : Request/response channel between the AXI-Lite read bridge and
//            the config read register fabric.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   read_addr  [ADDR_BITS] request address (bridge -> registers)
//   read_valid / read_ready  request handshake
//   resp_data  [DATA_BITS] response data (registers -> bridge)
//   resp_error               response error flag
//   resp_valid / resp_ready  response handshake
// Modports:
//   master : bridge side (issues requests, accepts responses)
//   slave  : register side
// ============================================================================
interface config_axil_read_bridge_if #(
   parameter int ADDR_BITS = 32,
   parameter int DATA_BITS = 64
);
   logic [ADDR_BITS-1:0] read_addr;
   logic                 read_valid;
   logic                 read_ready;
   logic [DATA_BITS-1:0] resp_data;
   logic                 resp_error;
   logic                 resp_valid;
   logic                 resp_ready;

   modport master (
      output read_addr,
      output read_valid,
      input  read_ready,
      input  resp_data,
      input  resp_error,
      input  resp_valid,
      output resp_ready
   );

   modport slave (
      input  read_addr,
      input  read_valid,
      output read_ready,
      output resp_data,
      output resp_error,
      output resp_valid,
      input  resp_ready
   );
endinterface
`default_nettype wire

// File: rtl/config_axil_read_bridge.sv
`default_nettype none
// ============================================================================
// Module   : config_axil_read_bridge
// Purpose  : AXI4-Lite read slave that turns each AR/R transaction into one
//            request/response on the config read interface. One read is
//            outstanding at a time; register errors map to SLVERR and a
//            silent register maps to DECERR after TIMEOUT cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_axil_ar*          AXI-Lite read address channel (araddr/arvalid/arready)
//   s_axil_r*           AXI-Lite read data channel (rdata/rresp/rvalid/rready)
//   conf                config request/response channel (master modport)
//   timeout_pulse       one-cycle pulse, aligned with the first rvalid cycle
//                       of a timed-out transaction
// ============================================================================
module config_axil_read_bridge #(
   parameter int AXIL_ADDR_BITS = 32,
   parameter int AXIL_DATA_BITS = 64,
   parameter int TIMEOUT        = 1024
) (
   input  wire logic                      clk,
   input  wire logic                      rst,
   input  wire logic [AXIL_ADDR_BITS-1:0] s_axil_araddr,
   input  wire logic                      s_axil_arvalid,
   output logic                           s_axil_arready,
   output logic      [AXIL_DATA_BITS-1:0] s_axil_rdata,
   output logic      [1:0]                s_axil_rresp,
   output logic                           s_axil_rvalid,
   input  wire logic                      s_axil_rready,
   config_axil_read_bridge_if.master      conf,
   output logic                           timeout_pulse
);

   // A zero-width counter is illegal, so TIMEOUT = 0 keeps a 1-bit stub.
   localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST =
      (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;

   localparam logic [1:0] c_RESP_OKAY   = 2'b00;
   localparam logic [1:0] c_RESP_SLVERR = 2'b10;
   localparam logic [1:0] c_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_FLUSH = 3'd4
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [c_CNT_W-1:0]        r_cnt;
   logic [AXIL_ADDR_BITS-1:0] r_read_addr;
   logic [AXIL_DATA_BITS-1:0] r_rdata;
   logic [1:0]                r_rresp;
   logic                      r_timeout_pulse;
   logic                      r_timed_out;   // WAIT timeout: late response must be flushed

   logic w_cnt_last;
   logic w_cnt_clr;
   logic w_load_addr;
   logic w_load_resp;
   logic w_expire;

   generate
      if (TIMEOUT > 0) begin : g_timeout
         assign w_cnt_last = (r_cnt == c_CNT_LAST);
      end else begin : g_no_timeout
         assign w_cnt_last = 1'b0;
      end
   endgenerate

   // Next-state decode. In REQ/WAIT a handshake is tested before expiry so
   // a handshake in the expiry cycle wins and no timeout is reported.
   always_comb begin
      w_state_next = r_state;
      w_cnt_clr    = 1'b0;
      w_load_addr  = 1'b0;
      w_load_resp  = 1'b0;
      w_expire     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (s_axil_arvalid) begin
               w_load_addr  = 1'b1;
               w_cnt_clr    = 1'b1;
               w_state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (conf.read_ready) begin
               w_cnt_clr    = 1'b1;
               w_state_next = S_WAIT;
            end else if (w_cnt_last) begin
               w_expire     = 1'b1;
               w_state_next = S_RESP;
            end
         end
         S_WAIT: begin
            if (conf.resp_valid) begin
               w_load_resp  = 1'b1;
               w_state_next = S_RESP;
            end else if (w_cnt_last) begin
               w_expire     = 1'b1;
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            if (s_axil_rready) begin
               if (r_timed_out) begin
                  w_cnt_clr    = 1'b1;
                  w_state_next = S_FLUSH;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         S_FLUSH: begin
            if (conf.resp_valid || w_cnt_last) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_read_addr     <= '0;
         r_rdata         <= '0;
         r_rresp         <= c_RESP_OKAY;
         r_timeout_pulse <= 1'b0;
         r_timed_out     <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_timeout_pulse <= w_expire;

         // Saturating counter; it only matters in REQ, WAIT and FLUSH,
         // each of which is entered with a clear.
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_load_addr) begin
            r_read_addr <= s_axil_araddr;
            r_timed_out <= 1'b0;
         end

         if (w_load_resp) begin
            r_rdata <= conf.resp_data;
            r_rresp <= conf.resp_error ? c_RESP_SLVERR : c_RESP_OKAY;
         end else if (w_expire) begin
            r_rdata     <= '0;
            r_rresp     <= c_RESP_DECERR;
            // A REQ timeout never handed the request over, so no response
            // can arrive late and no flush is needed.
            r_timed_out <= (r_state == S_WAIT);
         end
      end
   end

   // arready is the only output allowed to see an input (rst), which keeps
   // it low while reset is held.
   assign s_axil_arready  = (r_state == S_IDLE) && !rst;
   assign s_axil_rvalid   = (r_state == S_RESP);
   assign s_axil_rdata    = r_rdata;
   assign s_axil_rresp    = r_rresp;
   assign conf.read_addr  = r_read_addr;
   assign conf.read_valid = (r_state == S_REQ);
   assign conf.resp_ready = (r_state == S_WAIT) || (r_state == S_FLUSH);
   assign timeout_pulse   = r_timeout_pulse;

endmodule
`default_nettype wire

// File: tb/tb_config_axil_read_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_config_axil_read_bridge
// Purpose  : Directed self-checking bench for config_axil_read_bridge.
//            dut_a uses TIMEOUT = 8, dut_b uses TIMEOUT = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_axil_read_bridge;
   localparam int AW = 32;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_total;
   int n_bad;

   // ---------------- DUT A (TIMEOUT = 8) ----------------
   logic [AW-1:0] a_araddr;
   logic          a_arvalid, a_arready;
   logic [DW-1:0] a_rdata;
   logic [1:0]    a_rresp;
   logic          a_rvalid, a_rready, a_pulse;

   config_axil_read_bridge_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) conf_a ();

   config_axil_read_bridge #(
      .AXIL_ADDR_BITS(AW), .AXIL_DATA_BITS(DW), .TIMEOUT(8)
   ) dut_a (
      .clk            (clk),
      .rst            (rst),
      .s_axil_araddr  (a_araddr),
      .s_axil_arvalid (a_arvalid),
      .s_axil_arready (a_arready),
      .s_axil_rdata   (a_rdata),
      .s_axil_rresp   (a_rresp),
      .s_axil_rvalid  (a_rvalid),
      .s_axil_rready  (a_rready),
      .conf           (conf_a),
      .timeout_pulse  (a_pulse)
   );

   // ---------------- DUT B (TIMEOUT = 4) ----------------
   logic [AW-1:0] b_araddr;
   logic          b_arvalid, b_arready;
   logic [DW-1:0] b_rdata;
   logic [1:0]    b_rresp;
   logic          b_rvalid, b_rready, b_pulse;

   config_axil_read_bridge_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) conf_b ();

   config_axil_read_bridge #(
      .AXIL_ADDR_BITS(AW), .AXIL_DATA_BITS(DW), .TIMEOUT(4)
   ) dut_b (
      .clk            (clk),
      .rst            (rst),
      .s_axil_araddr  (b_araddr),
      .s_axil_arvalid (b_arvalid),
      .s_axil_arready (b_arready),
      .s_axil_rdata   (b_rdata),
      .s_axil_rresp   (b_rresp),
      .s_axil_rvalid  (b_rvalid),
      .s_axil_rready  (b_rready),
      .conf           (conf_b),
      .timeout_pulse  (b_pulse)
   );

   // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // AR handshake on dut_a; returns in cycle 1 (REQ).
   task automatic start_a(input logic [AW-1:0] addr);
      a_araddr  = addr;
      a_arvalid = 1'b1;
      tick();
      a_arvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_total++;
      if ({a_arready, a_rvalid, conf_a.read_valid, conf_a.resp_ready, a_pulse, a_rresp} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl got=%b want=0000000",
                  {a_arready, a_rvalid, conf_a.read_valid, conf_a.resp_ready, a_pulse, a_rresp});
      end
      n_total++;
      if (a_rdata !== '0 || conf_a.read_addr !== '0) begin
         n_bad++;
         $display("FAIL reset_data rdata=%h addr=%h want=0/0", a_rdata, conf_a.read_addr);
      end
      rst = 1'b0;
      tick();
      n_total++;
      if ({a_arready, b_arready, a_rvalid} !== 3'b110) begin
         n_bad++;
         $display("FAIL reset_release got=%b want=110", {a_arready, b_arready, a_rvalid});
      end
   endtask

   task automatic test_basic();
      conf_a.read_ready = 1'b1;
      conf_a.resp_valid = 1'b1;
      conf_a.resp_data  = 64'hDEADBEEF;
      conf_a.resp_error = 1'b0;
      start_a(32'h10);
      n_total++;
      if ({conf_a.read_valid, conf_a.read_addr, a_arready} !== {1'b1, 32'h10, 1'b0}) begin
         n_bad++;
         $display("FAIL basic_c1 valid=%b addr=%h arready=%b want 1/10/0",
                  conf_a.read_valid, conf_a.read_addr, a_arready);
      end
      tick();
      n_total++;
      if ({conf_a.resp_ready, conf_a.read_valid, a_rvalid} !== 3'b100) begin
         n_bad++;
         $display("FAIL basic_c2 got=%b want=100", {conf_a.resp_ready, conf_a.read_valid, a_rvalid});
      end
      tick();
      n_total++;
      if ({a_rvalid, a_rdata, a_rresp} !== {1'b1, 64'hDEADBEEF, 2'b00}) begin
         n_bad++;
         $display("FAIL basic_c3 rvalid=%b rdata=%h rresp=%b want 1/deadbeef/00", a_rvalid, a_rdata, a_rresp);
      end
      conf_a.resp_valid = 1'b0;
      conf_a.read_ready = 1'b0;
      a_rready = 1'b1;
      tick();
      a_rready = 1'b0;
      n_total++;
      if ({a_arready, a_rvalid} !== 2'b10) begin
         n_bad++;
         $display("FAIL basic_done got=%b want=10", {a_arready, a_rvalid});
      end
   endtask

   task automatic test_error();
      conf_a.read_ready = 1'b1;
      conf_a.resp_valid = 1'b1;
      conf_a.resp_data  = 64'h5;
      conf_a.resp_error = 1'b1;
      start_a(32'h14);
      tick();
      tick();
      n_total++;
      if ({a_rvalid, a_rdata, a_rresp, a_pulse} !== {1'b1, 64'h5, 2'b10, 1'b0}) begin
         n_bad++;
         $display("FAIL error_resp rvalid=%b rdata=%h rresp=%b pulse=%b want 1/5/10/0",
                  a_rvalid, a_rdata, a_rresp, a_pulse);
      end
      conf_a.resp_valid = 1'b0;
      conf_a.resp_error = 1'b0;
      conf_a.read_ready = 1'b0;
      a_rready = 1'b1;
      tick();
      a_rready = 1'b0;
   endtask

   task automatic test_backpressure();
      conf_a.read_ready = 1'b0;
      conf_a.resp_valid = 1'b0;
      start_a(32'h20);
      // Second AR held during the whole transaction with a different address.
      a_araddr  = 32'h99;
      a_arvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if ({conf_a.read_valid, conf_a.read_addr, a_arready} !== {1'b1, 32'h20, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_req[%0d] valid=%b addr=%h arready=%b want 1/20/0",
                     i, conf_a.read_valid, conf_a.read_addr, a_arready);
         end
         tick();
      end
      conf_a.read_ready = 1'b1;
      tick();
      conf_a.read_ready = 1'b0;
      conf_a.resp_valid = 1'b1;
      conf_a.resp_data  = 64'hABCD;
      tick();
      conf_a.resp_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         n_total++;
         if ({a_rvalid, a_rdata, a_rresp, a_arready} !== {1'b1, 64'hABCD, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_resp[%0d] rvalid=%b rdata=%h rresp=%b arready=%b want 1/abcd/00/0",
                     i, a_rvalid, a_rdata, a_rresp, a_arready);
         end
         tick();
      end
      a_rready = 1'b1;
      n_total++;
      if (a_arready !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_arready_n got=%b want=0", a_arready);
      end
      tick();
      a_rready = 1'b0;
      n_total++;
      if ({a_arready, a_rvalid} !== 2'b10) begin
         n_bad++;
         $display("FAIL bp_arready_n1 got=%b want=10", {a_arready, a_rvalid});
      end
      tick();
      a_arvalid = 1'b0;
      n_total++;
      if ({conf_a.read_valid, conf_a.read_addr} !== {1'b1, 32'h99}) begin
         n_bad++;
         $display("FAIL bp_second_ar valid=%b addr=%h want 1/99", conf_a.read_valid, conf_a.read_addr);
      end
      conf_a.read_ready = 1'b1;
      conf_a.resp_valid = 1'b1;
      conf_a.resp_data  = '0;
      tick();
      tick();
      conf_a.read_ready = 1'b0;
      conf_a.resp_valid = 1'b0;
      a_rready = 1'b1;
      tick();
      a_rready = 1'b0;
   endtask

   task automatic test_wait_timeout();
      int cyc;
      int pulses;
      conf_a.read_ready = 1'b1;
      conf_a.resp_valid = 1'b0;
      start_a(32'h30);
      tick();
      conf_a.read_ready = 1'b0;
      cyc    = 0;
      pulses = 0;
      while (!a_rvalid && cyc < 20) begin
         if (a_pulse) pulses++;
         tick();
         cyc++;
      end
      n_total++;
      if (cyc != 8) begin
         n_bad++;
         $display("FAIL to_latency got=%0d want=8 cycles in WAIT", cyc);
      end
      n_total++;
      if ({a_pulse, a_rdata, a_rresp} !== {1'b1, 64'h0, 2'b11}) begin
         n_bad++;
         $display("FAIL to_resp pulse=%b rdata=%h rresp=%b want 1/0/11", a_pulse, a_rdata, a_rresp);
      end
      if (a_pulse) pulses++;
      a_rready = 1'b1;
      tick();
      a_rready = 1'b0;
      if (a_pulse) pulses++;
      tick();
      if (a_pulse) pulses++;
      n_total++;
      if ({conf_a.resp_ready, a_arready, a_rvalid} !== 3'b100) begin
         n_bad++;
         $display("FAIL to_flush resp_ready/arready/rvalid got=%b want=100",
                  {conf_a.resp_ready, a_arready, a_rvalid});
      end
      n_total++;
      if (pulses != 1) begin
         n_bad++;
         $display("FAIL to_pulse_count got=%0d want=1", pulses);
      end
      conf_a.resp_valid = 1'b1;
      conf_a.resp_data  = 64'hBAD;
      tick();
      conf_a.resp_valid = 1'b0;
      n_total++;
      if ({a_arready, conf_a.resp_ready, a_rvalid} !== 3'b100) begin
         n_bad++;
         $display("FAIL to_flush_exit got=%b want=100", {a_arready, conf_a.resp_ready, a_rvalid});
      end
      conf_a.read_ready = 1'b1;
      conf_a.resp_valid = 1'b1;
      conf_a.resp_data  = 64'h77;
      start_a(32'h40);
      tick();
      tick();
      n_total++;
      if ({a_rvalid, a_rdata, a_rresp} !== {1'b1, 64'h77, 2'b00}) begin
         n_bad++;
         $display("FAIL to_next_read rvalid=%b rdata=%h rresp=%b want 1/77/00", a_rvalid, a_rdata, a_rresp);
      end
      conf_a.read_ready = 1'b0;
      conf_a.resp_valid = 1'b0;
      a_rready = 1'b1;
      tick();
      a_rready = 1'b0;
   endtask

   task automatic test_expiry_handshake();
      conf_b.read_ready = 1'b1;
      b_araddr  = 32'h50;
      b_arvalid = 1'b1;
      tick();
      b_arvalid = 1'b0;
      tick();
      conf_b.read_ready = 1'b0;
      repeat (3) tick();
      // Counter now sits at TIMEOUT-1: this is the expiry cycle.
      n_total++;
      if ({conf_b.resp_ready, b_rvalid, b_pulse} !== 3'b100) begin
         n_bad++;
         $display("FAIL exp_wait got=%b want=100", {conf_b.resp_ready, b_rvalid, b_pulse});
      end
      conf_b.resp_valid = 1'b1;
      conf_b.resp_data  = 64'h1234;
      conf_b.resp_error = 1'b0;
      tick();
      conf_b.resp_valid = 1'b0;
      n_total++;
      if ({b_rvalid, b_rdata, b_rresp, b_pulse} !== {1'b1, 64'h1234, 2'b00, 1'b0}) begin
         n_bad++;
         $display("FAIL exp_resp rvalid=%b rdata=%h rresp=%b pulse=%b want 1/1234/00/0",
                  b_rvalid, b_rdata, b_rresp, b_pulse);
      end
      b_rready = 1'b1;
      tick();
      b_rready = 1'b0;
      n_total++;
      if ({b_arready, conf_b.resp_ready} !== 2'b10) begin
         n_bad++;
         $display("FAIL exp_no_flush got=%b want=10", {b_arready, conf_b.resp_ready});
      end
   endtask

   task automatic test_reset_mid();
      conf_a.read_ready = 1'b1;
      conf_a.resp_valid = 1'b0;
      start_a(32'h60);
      tick();
      conf_a.read_ready = 1'b0;
      n_total++;
      if (conf_a.resp_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rm_wait resp_ready got=%b want=1", conf_a.resp_ready);
      end
      rst = 1'b1;
      tick();
      n_total++;
      if ({a_arready, a_rvalid, conf_a.read_valid, conf_a.resp_ready, a_pulse, a_rresp} !== 7'b0) begin
         n_bad++;
         $display("FAIL rm_ctrl got=%b want=0000000",
                  {a_arready, a_rvalid, conf_a.read_valid, conf_a.resp_ready, a_pulse, a_rresp});
      end
      n_total++;
      if (a_rdata !== '0 || conf_a.read_addr !== '0) begin
         n_bad++;
         $display("FAIL rm_data rdata=%h addr=%h want=0/0", a_rdata, conf_a.read_addr);
      end
      rst = 1'b0;
      tick();
      n_total++;
      if ({a_arready, a_rvalid, conf_a.resp_ready} !== 3'b100) begin
         n_bad++;
         $display("FAIL rm_release got=%b want=100", {a_arready, a_rvalid, conf_a.resp_ready});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_total   = 0;
      n_bad     = 0;
      a_araddr  = '0;
      a_arvalid = 1'b0;
      a_rready  = 1'b0;
      b_araddr  = '0;
      b_arvalid = 1'b0;
      b_rready  = 1'b0;
      conf_a.read_ready = 1'b0;
      conf_a.resp_data  = '0;
      conf_a.resp_error = 1'b0;
      conf_a.resp_valid = 1'b0;
      conf_b.read_ready = 1'b0;
      conf_b.resp_data  = '0;
      conf_b.resp_error = 1'b0;
      conf_b.resp_valid = 1'b0;

      test_reset();
      test_basic();
      test_error();
      test_backpressure();
      test_wait_timeout();
      test_expiry_handshake();
      test_reset_mid();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
